// File: rtl/picorv_trace_pkg.sv
// picorv_trace_pkg: shared widths and state encoding for the trace capture buffer.
package picorv_trace_pkg;
  localparam int TRACE_W = 36;
  localparam int DROP_CNT_W = 16;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_FROZEN  = 2'd3
  } trace_state_e;
endpackage

// File: rtl/picorv_trace_fifo_core.sv
// picorv_trace_fifo_core: first-word-fall-through circular FIFO with flush and occupancy count.
module picorv_trace_fifo_core #(
  parameter int DEPTH = 4,
  parameter int W = 36
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           data_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic do_push, do_pop;
  assign full_o = level_q == FULL_LVL;
  assign valid_o = level_q != '0;
  assign level_o = level_q;
  assign do_push = push_i & ~full_o;
  assign do_pop = pop_i & valid_o;
  // Empty output reads as zero so the unreset memory never leaks onto the bus.
  assign data_o = valid_o ? mem_q[rd_q] : '0;
  always_comb begin
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
      level_d = '0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/picorv_trace_capture.sv
// picorv_trace_capture: trace FIFO that keeps a fixed number of beats after a trap edge, then freezes.
module picorv_trace_capture
  import picorv_trace_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int POST_TRIG = 16
) (
  input  logic                    G0_CPU_CLK,
  input  logic                    G0_CPU_RST_N,
  input  logic                    i_arm,
  input  logic                    i_trace_valid,
  input  logic [TRACE_W-1:0]      i_trace_data,
  input  logic                    i_trap,
  output logic                    o_m_valid,
  output logic [TRACE_W-1:0]      o_m_data,
  input  logic                    i_m_ready,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic [DROP_CNT_W-1:0]   o_drop_cnt,
  output logic [1:0]              o_state,
  output logic                    o_frozen
);
  localparam int PW = POST_TRIG > 0 ? $clog2(POST_TRIG + 1) : 1;
  trace_state_e state_q, state_d;
  logic [PW-1:0] post_q, post_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic trap_q, trap_edge, capturing, push_req, full;
  assign trap_edge = i_trap & ~trap_q;
  assign capturing = state_q == ST_CAPTURE || state_q == ST_POST;
  // The arm cycle flushes, so a beat arriving with it is not kept.
  assign push_req = capturing & i_trace_valid & ~i_arm;
  assign o_state = state_q;
  assign o_frozen = state_q == ST_FROZEN;
  assign o_drop_cnt = drop_q;
  always_comb begin
    state_d = state_q;
    post_d = post_q;
    drop_d = (push_req && full && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    if (i_arm) begin
      state_d = ST_CAPTURE;
      drop_d = '0;
    end else if (state_q == ST_CAPTURE && trap_edge) begin
      state_d = POST_TRIG == 0 ? ST_FROZEN : ST_POST;
      post_d = PW'(POST_TRIG);
    end else if (state_q == ST_POST && i_trace_valid) begin
      post_d = post_q - 1'b1;
      state_d = post_q == PW'(1) ? ST_FROZEN : ST_POST;
    end
  end
  always_ff @(posedge G0_CPU_CLK or negedge G0_CPU_RST_N) begin
    if (!G0_CPU_RST_N) begin
      state_q <= ST_IDLE;
      post_q <= '0;
      drop_q <= '0;
      trap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      post_q <= post_d;
      drop_q <= drop_d;
      trap_q <= i_trap;
    end
  end
  picorv_trace_fifo_core #(
    .DEPTH(DEPTH),
    .W(TRACE_W)
  ) u_fifo (
    .clk_i(G0_CPU_CLK),
    .rst_ni(G0_CPU_RST_N),
    .flush_i(i_arm),
    .push_i(push_req),
    .pop_i(i_m_ready),
    .data_i(i_trace_data),
    .data_o(o_m_data),
    .valid_o(o_m_valid),
    .full_o(full),
    .level_o(o_level)
  );
endmodule

// File: tb/tb_picorv_trace_capture.sv
// tb_picorv_trace_capture: directed and random checks of two capture buffer configurations.
module tb_picorv_trace_capture;
  localparam int PT_A = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic arm_a = 0, v_a = 0, trap_a = 0, rdy_a = 0;
  logic arm_b = 0, v_b = 0, trap_b = 0, rdy_b = 0;
  logic [35:0] d_a = '0, d_b = '0, md_a, md_b;
  logic mv_a, mv_b, fr_a, fr_b;
  logic [2:0] lvl_a;
  logic [4:0] lvl_b;
  logic [15:0] drop_a, drop_b;
  logic [1:0] st_a, st_b;
  int n_chk = 0, n_pass = 0;
  logic [35:0] q[$];
  int m_state = 0, m_drop = 0, m_post = 0;
  bit m_trap = 0;

  always #5 clk = ~clk;

  picorv_trace_capture #(.DEPTH(4), .POST_TRIG(PT_A)) u_a (
    .G0_CPU_CLK(clk), .G0_CPU_RST_N(rst_n), .i_arm(arm_a), .i_trace_valid(v_a),
    .i_trace_data(d_a), .i_trap(trap_a), .o_m_valid(mv_a), .o_m_data(md_a),
    .i_m_ready(rdy_a), .o_level(lvl_a), .o_drop_cnt(drop_a), .o_state(st_a), .o_frozen(fr_a)
  );
  picorv_trace_capture #(.DEPTH(16), .POST_TRIG(0)) u_b (
    .G0_CPU_CLK(clk), .G0_CPU_RST_N(rst_n), .i_arm(arm_b), .i_trace_valid(v_b),
    .i_trace_data(d_b), .i_trap(trap_b), .o_m_valid(mv_b), .o_m_data(md_b),
    .i_m_ready(rdy_b), .o_level(lvl_b), .o_drop_cnt(drop_b), .o_state(st_b), .o_frozen(fr_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_drop = 0;
    m_post = 0;
    m_trap = 0;
  endtask

  // Queue-level behaviour of the DEPTH=4 buffer for one clock edge.
  task automatic model_step(input bit arm, input bit v, input logic [35:0] d, input bit t, input bit r);
    bit edge_t, was_full;
    edge_t = t && !m_trap;
    was_full = q.size() == 4;
    m_trap = t;
    if (arm) begin
      q.delete();
      m_drop = 0;
      m_state = 1;
      return;
    end
    if (r && q.size() > 0) void'(q.pop_front());
    if (v && (m_state == 1 || m_state == 2)) begin
      if (was_full) m_drop = m_drop == 65535 ? m_drop : m_drop + 1;
      else q.push_back(d);
    end
    if (m_state == 1 && edge_t) begin
      m_post = PT_A;
      m_state = PT_A == 0 ? 3 : 2;
    end else if (m_state == 2 && v) begin
      m_post--;
      if (m_post == 0) m_state = 3;
    end
  endtask

  task automatic check_a();
    logic [35:0] head;
    head = '0;
    if (q.size() > 0) head = q[0];
    chk("a_level", lvl_a, q.size());
    chk("a_valid", mv_a, q.size() != 0);
    chk("a_data", md_a, head);
    chk("a_drop", drop_a, m_drop);
    chk("a_state", st_a, m_state);
    chk("a_frozen", fr_a, m_state == 3);
  endtask

  task automatic cyc_a(input bit arm, input bit v, input logic [35:0] d, input bit t, input bit r);
    arm_a = arm; v_a = v; d_a = d; trap_a = t; rdy_a = r;
    model_step(arm, v, d, t, r);
    @(posedge clk);
    #1;
    check_a();
  endtask

  task automatic cyc_b(input bit arm, input bit v, input logic [35:0] d, input bit t, input bit r);
    arm_b = arm; v_b = v; d_b = d; trap_b = t; rdy_b = r;
    @(posedge clk);
    #1;
    arm_b = 0; v_b = 0; rdy_b = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_a();
    chk("b_rst_level", lvl_b, 0);
    chk("b_rst_valid", mv_b, 0);
    chk("b_rst_data", md_b, 0);
    chk("b_rst_state", st_b, 0);
    chk("b_rst_frozen", fr_b, 0);
    rst_n = 1'b1;
    // B: fill, then drain in order
    cyc_b(1, 0, 0, 0, 0);
    chk("b_armed", st_b, 1);
    for (int i = 1; i <= 10; i++) cyc_b(0, 1, 36'(i), 0, 0);
    chk("b_level10", lvl_b, 10);
    chk("b_head1", md_b, 1);
    for (int i = 1; i <= 10; i++) begin
      chk("b_drain", md_b, i);
      cyc_b(0, 0, 0, 0, 1);
    end
    chk("b_empty", lvl_b, 0);
    chk("b_empty_valid", mv_b, 0);
    // B: POST_TRIG=0 freezes on the trap edge, arm flushes
    for (int i = 0; i < 3; i++) cyc_b(0, 1, 36'h11 + 36'(i), 0, 0);
    cyc_b(0, 1, 36'h14, 1, 0);
    chk("b_frozen_state", st_b, 3);
    chk("b_frozen", fr_b, 1);
    chk("b_frozen_level", lvl_b, 4);
    cyc_b(0, 1, 36'h15, 1, 0);
    chk("b_frozen_nowrite", lvl_b, 4);
    chk("b_frozen_nodrop", drop_b, 0);
    cyc_b(1, 0, 0, 0, 0);
    chk("b_rearm_level", lvl_b, 0);
    chk("b_rearm_state", st_b, 1);
    chk("b_rearm_drop", drop_b, 0);
    chk("b_rearm_frozen", fr_b, 0);
    // A: overflow drops
    cyc_a(1, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) cyc_a(0, 1, 36'(i), 0, 0);
    chk("a_full_level", lvl_a, 4);
    chk("a_drop3", drop_a, 3);
    for (int i = 1; i <= 4; i++) begin
      chk("a_kept", md_a, i);
      cyc_a(0, 0, 0, 0, 1);
    end
    // A: trap with POST_TRIG=3
    cyc_a(1, 0, 0, 0, 0);
    cyc_a(0, 1, 36'h100, 1, 0);
    chk("a_post", st_a, 2);
    for (int k = 1; k <= 5; k++) begin
      cyc_a(0, 1, 36'h100 + 36'(k), 1, 0);
      if (k == 2) chk("a_post_k2", st_a, 2);
      if (k == 3) chk("a_frozen_k3", st_a, 3);
    end
    chk("a_post_level", lvl_a, 4);
    chk("a_post_nodrop", drop_a, 0);
    for (int i = 0; i < 4; i++) begin
      chk("a_post_word", md_a, 36'h100 + 36'(i));
      cyc_a(0, 0, 0, 0, 1);
    end
    // A: wrap with simultaneous push and pop
    cyc_a(1, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      cyc_a(0, 1, 36'h200 + 36'(k), 0, 1);
      chk("a_wrap_head", md_a, 36'h200 + 36'(k));
    end
    chk("a_wrap_drop", drop_a, 0);
    // A: asynchronous reset in POST
    cyc_a(1, 0, 0, 0, 0);
    cyc_a(0, 1, 36'h301, 0, 0);
    cyc_a(0, 1, 36'h302, 0, 0);
    cyc_a(0, 1, 36'h303, 1, 0);
    chk("a_pre_rst_level", lvl_a, 3);
    chk("a_pre_rst_state", st_a, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("a_arst_state", st_a, 0);
    chk("a_arst_level", lvl_a, 0);
    chk("a_arst_valid", mv_a, 0);
    model_reset();
    #1 rst_n = 1'b1;
    cyc_a(0, 1, 36'h304, 0, 0);
    // A: random traffic
    for (int n = 0; n < 400; n++) begin
      cyc_a($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6, {$urandom_range(0, 15), $urandom},
            $urandom_range(0, 3) == 0 ? ~trap_a : trap_a, $urandom_range(0, 9) < 4);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
